// File: rtl/ddr3_traffic_sequencer.sv
// DDR3 traffic sequencer for the MIG 7-series app_* interface (ui_clk domain).
// Writes a deterministic pattern over an address window, reads it back and
// compares every returned word, reporting pass/fail, error count and the
// index of the first failing word.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start or the auto trigger (calibration rising edge)
// WRITE | write commands and write data issued on independent channels
// READ  | read commands issued while returned data is checked in order
// FLUSH | all read commands accepted; waiting for the remaining read data
// DONE  | one cycle: publish done/pass, then back to IDLE
module ddr3_traffic_sequencer #(
    parameter int          ADDR_WIDTH = 30,
    parameter int          DATA_WIDTH = 256,
    parameter int          NUM_WORDS  = 1024,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned ADDR_STEP  = 8,
    parameter logic [31:0] SEED       = 32'hA5A5_0000,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                      ui_clk,
    input  logic                      reset_n,
    input  logic                      init_calib_complete,
    input  logic                      start,
    input  logic                      app_rdy,
    input  logic                      app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]     app_rd_data,
    input  logic                      app_rd_data_valid,
    output logic [ADDR_WIDTH-1:0]     app_addr,
    output logic [2:0]                app_cmd,
    output logic                      app_en,
    output logic [DATA_WIDTH-1:0]     app_wdf_data,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [15:0]               err_count,
    output logic [31:0]               first_err_idx
);

    localparam int              LANES  = DATA_WIDTH / 32;
    localparam logic [31:0]     NW     = 32'(NUM_WORDS);
    localparam logic [2:0]      CMD_WR = 3'b000;
    localparam logic [2:0]      CMD_RD = 3'b001;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] cmd_idx;
    logic [31:0] data_idx;
    logic [31:0] rd_idx;
    logic        err_seen;
    logic        calib_q;

    logic        cmd_fire;
    logic        data_fire;
    logic [31:0] cmd_idx_n;
    logic [31:0] data_idx_n;
    logic        calib_rise;
    logic        trigger;
    logic        abort;
    logic        rd_active;
    logic        rd_hit;
    logic        rd_in_range;
    logic        rd_bad;
    logic        rd_first;
    logic [31:0] rd_idx_n;
    logic [15:0] err_count_n;

    // Lane k of word i is {i[23:0], k[7:0]} ^ SEED.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] idx);
        logic [DATA_WIDTH-1:0] p;
        p = '0;
        for (int k = 0; k < LANES; k++) begin
            p[32*k +: 32] = {idx[23:0], 8'(k)} ^ SEED;
        end
        return p;
    endfunction

    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;

    // Handshakes, auto trigger, abort and read-back compare for this cycle.
    always_comb begin
        cmd_fire    = app_en & app_rdy;
        data_fire   = app_wdf_wren & app_wdf_rdy;
        cmd_idx_n   = cmd_idx + {31'd0, cmd_fire};
        data_idx_n  = data_idx + {31'd0, data_fire};
        calib_rise  = init_calib_complete & ~calib_q;
        trigger     = init_calib_complete & (start | (AUTO_START & calib_rise));
        abort       = ((state == WRITE) || (state == READ) || (state == FLUSH))
                      && !init_calib_complete;
        rd_active   = (state == READ) || (state == FLUSH) || (state == DONE);
        rd_hit      = rd_active & app_rd_data_valid;
        rd_in_range = (rd_idx < NW);
        rd_bad      = 1'b0;
        if (rd_hit) begin
            // Data beyond the last expected word is always an error.
            rd_bad = !rd_in_range || (app_rd_data != pattern(rd_idx));
        end
        rd_first    = rd_bad && rd_in_range && !err_seen;
        rd_idx_n    = (rd_hit && rd_in_range) ? rd_idx + 32'd1 : rd_idx;
        err_count_n = (rd_bad && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;
    end

    // Sequencer FSM with registered app_* and status outputs.
    always_ff @(posedge ui_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cmd_idx       <= '0;
            data_idx      <= '0;
            rd_idx        <= '0;
            err_seen      <= 1'b0;
            calib_q       <= 1'b0;
            app_addr      <= '0;
            app_cmd       <= '0;
            app_en        <= 1'b0;
            app_wdf_data  <= '0;
            app_wdf_wren  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            calib_q <= init_calib_complete;

            if (rd_active && !abort) begin
                rd_idx    <= rd_idx_n;
                err_count <= err_count_n;
                if (rd_first) begin
                    first_err_idx <= rd_idx;
                    err_seen      <= 1'b1;
                end
            end

            if (abort) begin
                // Calibration lost: stop driving MIG, keep the error tally.
                state        <= IDLE;
                app_en       <= 1'b0;
                app_wdf_wren <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (trigger) begin
                            state         <= WRITE;
                            busy          <= 1'b1;
                            done          <= 1'b0;
                            pass          <= 1'b0;
                            err_count     <= '0;
                            first_err_idx <= '0;
                            err_seen      <= 1'b0;
                            cmd_idx       <= '0;
                            data_idx      <= '0;
                            rd_idx        <= '0;
                            app_en        <= 1'b1;
                            app_cmd       <= CMD_WR;
                            app_addr      <= BASE;
                            app_wdf_wren  <= 1'b1;
                            app_wdf_data  <= pattern(32'd0);
                        end
                    end
                    WRITE: begin
                        cmd_idx  <= cmd_idx_n;
                        data_idx <= data_idx_n;
                        if (cmd_fire) begin
                            app_addr <= app_addr + STEP;
                        end
                        app_en       <= (cmd_idx_n < NW);
                        // Data may run at most two words ahead of commands.
                        app_wdf_wren <= (data_idx_n < NW) && (data_idx_n < cmd_idx_n + 32'd2);
                        app_wdf_data <= pattern(data_idx_n);
                        if ((cmd_idx_n == NW) && (data_idx_n == NW)) begin
                            state        <= READ;
                            cmd_idx      <= '0;
                            app_en       <= 1'b1;
                            app_cmd      <= CMD_RD;
                            app_addr     <= BASE;
                            app_wdf_wren <= 1'b0;
                        end
                    end
                    READ: begin
                        cmd_idx <= cmd_idx_n;
                        if (cmd_fire) begin
                            app_addr <= app_addr + STEP;
                        end
                        if (cmd_idx_n == NW) begin
                            app_en <= 1'b0;
                            state  <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        if (rd_idx == NW) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_count_n == 16'd0);
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr3_traffic_sequencer.sv
// Scoreboard bench for ddr3_traffic_sequencer with a small MIG model.
module tb_ddr3_traffic_sequencer;

    localparam int NW = 16;
    localparam int DW = 64;
    localparam int AW = 30;

    logic            ui_clk;
    logic            reset_n;
    logic            init_calib_complete;
    logic            start;
    logic            app_rdy;
    logic            app_wdf_rdy;
    logic [DW-1:0]   app_rd_data;
    logic            app_rd_data_valid;
    logic [AW-1:0]   app_addr;
    logic [2:0]      app_cmd;
    logic            app_en;
    logic [DW-1:0]   app_wdf_data;
    logic            app_wdf_wren;
    logic            app_wdf_end;
    logic [DW/8-1:0] app_wdf_mask;
    logic            busy;
    logic            done;
    logic            pass;
    logic [15:0]     err_count;
    logic [31:0]     first_err_idx;

    ddr3_traffic_sequencer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW)
    ) dut (
        .ui_clk              (ui_clk),
        .reset_n             (reset_n),
        .init_calib_complete (init_calib_complete),
        .start               (start),
        .app_rdy             (app_rdy),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_mask        (app_wdf_mask),
        .busy                (busy),
        .done                (done),
        .pass                (pass),
        .err_count           (err_count),
        .first_err_idx       (first_err_idx)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    typedef struct {
        logic [15:0] err;
        logic [31:0] first;
        logic        ok;
    } result_t;

    typedef struct {
        int due;
        int idx;
    } ret_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [AW-1:0] exp_wr_addr[$];
    logic [AW-1:0] exp_rd_addr[$];
    logic [DW-1:0] exp_wr_data[$];
    result_t     exp_res[$];
    ret_t        pending[$];

    int          cyc = 0;
    bit          rdy_random = 0;
    int          wdf_stall_at = -1;
    int          stall_left = 0;
    bit          corrupt_en = 0;
    bit          stray_req = 0;
    int          wr_cmd_cnt, wr_data_cnt, rd_cmd_cnt, rd_ret_cnt;
    logic [31:0] w2_lane0;
    bit          done_q = 0;
    ret_t        r;
    logic [DW-1:0] d;
    result_t     er;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [DW-1:0] p;
        logic [31:0]   iv;
        iv = i;
        for (int k = 0; k < DW/32; k++) begin
            p[32*k +: 32] = {iv[23:0], 8'(k)} ^ 32'hA5A5_0000;
        end
        return p;
    endfunction

    // Load expectations for one full run (BASE_ADDR=0, step 8).
    task automatic push_run();
        exp_wr_addr.delete();
        exp_rd_addr.delete();
        exp_wr_data.delete();
        exp_res.delete();
        wr_cmd_cnt  = 0;
        wr_data_cnt = 0;
        rd_cmd_cnt  = 0;
        rd_ret_cnt  = 0;
        for (int i = 0; i < NW; i++) begin
            exp_wr_addr.push_back(AW'(i * 8));
            exp_rd_addr.push_back(AW'(i * 8));
            exp_wr_data.push_back(pat(i));
        end
    endtask

    task automatic push_result(input int e, input int f, input bit ok);
        result_t x;
        x.err   = 16'(e);
        x.first = 32'(f);
        x.ok    = ok;
        exp_res.push_back(x);
    endtask

    task automatic pulse_start();
        @(posedge ui_clk); #1 start = 1'b1;
        @(posedge ui_clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        repeat (2) @(negedge ui_clk);
        while (!done && n < max_cycles) begin
            @(negedge ui_clk);
            n++;
        end
        check("done_timeout", done, 1);
        repeat (2) @(negedge ui_clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a handshake.
    always @(negedge ui_clk) begin
        if (reset_n) begin
            if (app_wdf_wren && app_wdf_rdy) begin
                check("wdf_lead", (wr_data_cnt - wr_cmd_cnt <= 1), 1);
                check("wdf_end", app_wdf_end, 1);
                check("wdf_mask", app_wdf_mask, 0);
                if (exp_wr_data.size() == 0) check("wr_data_extra", wr_data_cnt, NW);
                else check("wr_data", app_wdf_data, exp_wr_data.pop_front());
                if (wr_data_cnt == 2) w2_lane0 = app_wdf_data[31:0];
                wr_data_cnt++;
            end
            if (app_en && app_rdy) begin
                if (app_cmd == 3'b000) begin
                    if (exp_wr_addr.size() == 0) check("wr_cmd_extra", wr_cmd_cnt, NW);
                    else check("wr_addr", app_addr, exp_wr_addr.pop_front());
                    wr_cmd_cnt++;
                end else begin
                    check("rd_cmd_code", app_cmd, 3'b001);
                    if (exp_rd_addr.size() == 0) check("rd_cmd_extra", rd_cmd_cnt, NW);
                    else check("rd_addr", app_addr, exp_rd_addr.pop_front());
                    r.due = cyc + 20;
                    r.idx = rd_cmd_cnt;
                    pending.push_back(r);
                    rd_cmd_cnt++;
                end
            end
            if (done && !done_q) begin
                if (exp_res.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    er = exp_res.pop_front();
                    check("err_count", err_count, er.err);
                    check("first_err_idx", first_err_idx, er.first);
                    check("pass", pass, er.ok);
                    check("busy_at_done", busy, 0);
                end
            end
            done_q = done;
        end else begin
            done_q = 1'b0;
        end
    end

    // MIG model: ready generation and in-order read return after 20 cycles.
    always @(posedge ui_clk) begin
        cyc++;
        #1;
        if (!reset_n) begin
            app_rd_data_valid = 1'b0;
        end else begin
            app_rdy = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wdf_stall_at >= 0 && wr_data_cnt == wdf_stall_at) begin
                stall_left   = 5;
                wdf_stall_at = -1;
            end
            if (stall_left > 0) begin
                app_wdf_rdy = 1'b0;
                stall_left--;
            end else begin
                app_wdf_rdy = 1'b1;
            end
            if (pending.size() > 0 && pending[0].due <= cyc) begin
                r = pending.pop_front();
                d = pat(r.idx);
                if (corrupt_en && r.idx == 2) d[31:0] = d[31:0] ^ 32'h1;
                if (corrupt_en && r.idx == 9) d = ~d;
                app_rd_data       = d;
                app_rd_data_valid = 1'b1;
                rd_ret_cnt++;
            end else if (stray_req && rd_ret_cnt == NW && pending.size() == 0) begin
                app_rd_data       = pat(0);
                app_rd_data_valid = 1'b1;
                stray_req         = 1'b0;
            end else begin
                app_rd_data_valid = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n             = 1'b0;
        init_calib_complete = 1'b0;
        start               = 1'b0;
        app_rdy             = 1'b1;
        app_wdf_rdy         = 1'b1;
        app_rd_data         = '0;
        app_rd_data_valid   = 1'b0;
        w2_lane0            = '0;
        push_run();
        repeat (3) @(posedge ui_clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge ui_clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_app_en", app_en, 0);
        check("rst_wren", app_wdf_wren, 0);
        check("rst_err", err_count, 0);
        check("rst_first", first_err_idx, 0);

        // Run A: ideal MIG, auto start on calibration rising edge
        push_run();
        push_result(0, 0, 1);
        @(posedge ui_clk); #1 init_calib_complete = 1'b1;
        @(negedge ui_clk);
        check("lat_before", app_en, 0);
        @(negedge ui_clk);
        check("lat_first_en", app_en, 1);
        check("busy_running", busy, 1);
        wait_done(300);
        check("word2_lane0", w2_lane0, 32'hA5A5_0200);
        check("a_wr_cmds", wr_cmd_cnt, NW);
        check("a_rd_rets", rd_ret_cnt, NW);
        repeat (5) @(negedge ui_clk);
        check("done_held", done, 1);
        check("pass_held", pass, 1);

        // Run B: random app_rdy, write-data stall mid-write
        rdy_random   = 1'b1;
        wdf_stall_at = 6;
        push_run();
        push_result(0, 0, 1);
        pulse_start();
        wait_done(2000);
        check("b_wr_cmds", wr_cmd_cnt, NW);
        check("b_wr_data", wr_data_cnt, NW);
        check("b_rd_cmds", rd_cmd_cnt, NW);
        check("b_rd_rets", rd_ret_cnt, NW);
        rdy_random = 1'b0;

        // Run C: corrupted read data on words 2 and 9
        corrupt_en = 1'b1;
        push_run();
        push_result(2, 2, 0);
        pulse_start();
        wait_done(300);
        corrupt_en = 1'b0;

        // Run D: calibration lost during WRITE, then auto rerun
        push_run();
        pulse_start();
        n = 0;
        while (wr_data_cnt < 5 && n < 100) begin
            @(negedge ui_clk);
            n++;
        end
        check("d_reach_word5", (wr_data_cnt >= 5), 1);
        @(posedge ui_clk); #1 init_calib_complete = 1'b0;
        @(negedge ui_clk);
        @(negedge ui_clk);
        check("abort_app_en", app_en, 0);
        check("abort_wren", app_wdf_wren, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (3) @(negedge ui_clk);
        check("abort_stays_idle", busy, 0);
        push_run();
        push_result(0, 0, 1);
        @(posedge ui_clk); #1 init_calib_complete = 1'b1;
        wait_done(300);

        // Run E: reset asserted mid-READ, then a full run after release
        push_run();
        pulse_start();
        n = 0;
        while (rd_cmd_cnt < 5 && n < 200) begin
            @(negedge ui_clk);
            n++;
        end
        check("e_reach_read", (rd_cmd_cnt >= 5), 1);
        @(posedge ui_clk); #2 reset_n = 1'b0;
        pending.delete();
        app_rd_data_valid = 1'b0;
        #1;
        check("arst_app_en", app_en, 0);
        check("arst_app_addr", app_addr, 0);
        check("arst_app_cmd", app_cmd, 0);
        check("arst_wren", app_wdf_wren, 0);
        check("arst_wdata", app_wdf_data, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err_count, 0);
        push_run();
        push_result(0, 0, 1);
        repeat (2) @(posedge ui_clk);
        #1 reset_n = 1'b1;
        start = 1'b1;
        @(posedge ui_clk); #1 start = 1'b0;
        wait_done(300);
        check("e_rd_rets", rd_ret_cnt, NW);

        // Run F: start while busy is ignored; stray read word after the last
        push_run();
        push_result(1, 0, 0);
        stray_req = 1'b1;
        pulse_start();
        repeat (3) @(posedge ui_clk);
        #1 start = 1'b1;
        @(posedge ui_clk); #1 start = 1'b0;
        @(negedge ui_clk);
        check("f_busy_during", busy, 1);
        wait_done(300);
        check("f_wr_cmds", wr_cmd_cnt, NW);
        check("f_stray_sent", stray_req, 0);

        check("leftover_expect",
              exp_wr_addr.size() + exp_rd_addr.size() + exp_wr_data.size() + exp_res.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
